// File: rtl/logic_gate_pipe_pkg.sv
// Gate-select encoding and the per-bit gate function shared by the pipe datapath.
// Every gate is purely bitwise, so the function is defined on a single bit and replicated across the word.
package logic_gate_pipe_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_BUF  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_XNOR = 3'd7
    } gate_op_e;

    // NOT and BUF look only at operand A.
    function automatic logic logic_gate_eval(input op_t op, input logic a, input logic b);
        logic r;
        r = a;
        case (op)
            OP_NOT:  r = ~a;
            OP_BUF:  r = a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Upstream beat (in_valid/in_ready/op/a/b) and downstream result (out_valid/out_ready/y) of the gate pipe.
// master = the environment driving beats and sinking results; slave = the pipe itself.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8
);
    import logic_gate_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y
    );

endinterface

// File: rtl/logic_gate_pipe_stage.sv
// One pipe slot: valid bit plus data word, both updated only when the slot advances.
// Data is kept on bubble loads so y does not toggle while the slot is empty.
module logic_gate_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_load) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise gate unit (NOT..XNOR) evaluated at the input and carried through STAGES slots; latency STAGES cycles.
// Ready ripples combinationally from out_ready to in_ready; bubbles collapse, so in_ready drops only when every slot is full.
module logic_gate_pipe
    import logic_gate_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_gate_pipe_if.slave   bus,
    output logic [CNT_W-1:0]   done_cnt
);

    logic [WIDTH-1:0]  w_gate;
    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_dat [STAGES];
    logic              w_xfer;
    logic [CNT_W-1:0]  r_done_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_gate[i] = logic_gate_eval(bus.op, bus.a[i], bus.b[i]);
    end

    // Slot k may advance when it, or any slot after it, is empty, or the sink is taking the head.
    // Written in closed form to keep the ready path free of bit-level self reference.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign w_adv[k] = ~(&w_vld[STAGES-1:k]) | bus.out_ready;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_src_vld;
        logic [WIDTH-1:0] w_src_dat;

        if (k == 0) begin : g_head
            assign w_src_vld = bus.in_valid;
            assign w_src_dat = w_gate;
        end else begin : g_body
            assign w_src_vld = w_vld[k-1];
            assign w_src_dat = w_dat[k-1];
        end

        logic_gate_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_adv[k]),
            .i_vld  (w_src_vld),
            .i_dat  (w_src_dat),
            .o_vld  (w_vld[k]),
            .o_dat  (w_dat[k])
        );
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = w_vld[STAGES-1];
    assign bus.y         = w_dat[STAGES-1];

    assign w_xfer = w_vld[STAGES-1] & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (w_xfer) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
        end
    end

    assign done_cnt = r_done_cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Random and directed stimulus against an event-level model: a FIFO of results, each due STAGES cycles after
// accept or one cycle after its predecessor leaves, whichever is later; ready falls only with STAGES held and no sink.
module tb_logic_gate_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic [15:0] done_cnt;
    logic [3:0]  done_cnt_w;

    logic_gate_pipe_if #(.WIDTH(W)) m_if ();
    logic_gate_pipe_if #(.WIDTH(W)) w_if ();

    assign w_if.in_valid  = m_if.in_valid;
    assign w_if.op        = m_if.op;
    assign w_if.a         = m_if.a;
    assign w_if.b         = m_if.b;
    assign w_if.out_ready = m_if.out_ready;

    logic_gate_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (m_if),
        .done_cnt (done_cnt)
    );

    logic_gate_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(4)) u_dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (w_if),
        .done_cnt (done_cnt_w)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_gate(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0: return ~a;
            1: return a;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a & b);
            6: return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } item_t;

    item_t        mq[$];
    int           m_done = 0;
    logic [W-1:0] out_hist[$];
    int           out_cyc[$];
    int           acc_cyc[$];

    // Monitor: compares every observable output once per cycle, then advances the model by this cycle's handshakes.
    always @(negedge clk) begin
        logic  exp_rdy;
        logic  exp_ov;
        item_t it;
        if (!rst_n) begin
            mq.delete();
            m_done = 0;
            check("rst_out_valid", m_if.out_valid, 1'b0);
            check("rst_y", m_if.y, '0);
            check("rst_done_cnt", done_cnt, 16'd0);
        end else begin
            exp_rdy = (mq.size() < S) || m_if.out_ready;
            exp_ov  = 1'b0;
            if (mq.size() > 0) exp_ov = (cyc >= mq[0].due);
            check("in_ready", m_if.in_ready, exp_rdy);
            check("out_valid", m_if.out_valid, exp_ov);
            if (exp_ov) check("y", m_if.y, mq[0].d);
            check("done_cnt", done_cnt, m_done);
            check("done_cnt_w", done_cnt_w, m_done % 16);
            if (exp_ov && m_if.out_ready) begin
                out_hist.push_back(m_if.y);
                out_cyc.push_back(cyc);
                void'(mq.pop_front());
                m_done++;
                if (mq.size() > 0 && mq[0].due < cyc + 1) begin
                    it = mq[0];
                    it.due = cyc + 1;
                    mq[0] = it;
                end
            end
            if (exp_rdy && m_if.in_valid) begin
                it.d   = ref_gate(int'(m_if.op), m_if.a, m_if.b);
                it.due = cyc + S;
                mq.push_back(it);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m_if.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [W-1:0] ops_exp [8];
    logic [W-1:0] exp_q[$];

    initial begin
        int ob, ab, lows, unstable, ov_seen;
        logic took, have;
        logic [W-1:0] yref;

        ops_exp[0] = 8'h5A; ops_exp[1] = 8'hA5; ops_exp[2] = 8'h24; ops_exp[3] = 8'hBD;
        ops_exp[4] = 8'h99; ops_exp[5] = 8'hDB; ops_exp[6] = 8'h42; ops_exp[7] = 8'h66;

        rst_n = 1'b0;
        m_if.in_valid = 1'b0; m_if.out_ready = 1'b0;
        m_if.op = '0; m_if.a = '0; m_if.b = '0;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check("idle_out_valid", m_if.out_valid, 1'b0);
        check("idle_y", m_if.y, '0);
        check("idle_done_cnt", done_cnt, 16'd0);
        check("idle_in_ready", m_if.in_ready, 1'b1);
        step();

        // All eight gates on fixed operands.
        ob = out_hist.size(); ab = acc_cyc.size();
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_if.in_valid = 1'b1; m_if.op = 3'(i); m_if.a = 8'hA5; m_if.b = 8'h3C;
            step();
        end
        m_if.in_valid = 1'b0;
        repeat (S + 3) step();
        check("ops_count", out_hist.size() - ob, 8);
        for (int i = 0; i < 8; i++) begin
            if (ob + i < out_hist.size() && ab + i < acc_cyc.size()) begin
                check($sformatf("ops_y_%0d", i), out_hist[ob+i], ops_exp[i]);
                check($sformatf("ops_lat_%0d", i), out_cyc[ob+i] - acc_cyc[ab+i], S);
            end
        end

        // Streaming: 20 back-to-back random beats.
        do_reset();
        ob = out_hist.size(); lows = 0; exp_q.delete();
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            m_if.in_valid = 1'b1;
            m_if.op = 3'($urandom_range(0, 7)); m_if.a = 8'($urandom); m_if.b = 8'($urandom);
            exp_q.push_back(ref_gate(int'(m_if.op), m_if.a, m_if.b));
            #1;
            if (!m_if.in_ready) lows++;
            step();
        end
        m_if.in_valid = 1'b0;
        repeat (S + 3) step();
        check("stream_ready_low", lows, 0);
        check("stream_count", out_hist.size() - ob, 20);
        check("stream_done_cnt", done_cnt, 16'd20);
        for (int i = 0; i < 20; i++) begin
            if (ob + i < out_hist.size()) check($sformatf("stream_y_%0d", i), out_hist[ob+i], exp_q[i]);
            if (i > 0 && ob + i < out_hist.size()) check("stream_gap", out_cyc[ob+i] - out_cyc[ob+i-1], 1);
        end

        // Backpressure: sink stalled for 10 cycles.
        ob = out_hist.size(); ab = acc_cyc.size(); exp_q.delete();
        unstable = 0; have = 1'b0; took = 1'b1;
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (took) begin
                m_if.in_valid = 1'b1;
                m_if.op = 3'($urandom_range(0, 7)); m_if.a = 8'($urandom); m_if.b = 8'($urandom);
            end
            #1;
            took = m_if.in_valid && m_if.in_ready;
            if (took) exp_q.push_back(ref_gate(int'(m_if.op), m_if.a, m_if.b));
            if (m_if.out_valid) begin
                if (!have) begin yref = m_if.y; have = 1'b1; end
                else if (m_if.y !== yref) unstable++;
            end
            step();
        end
        check("bp_accepted", acc_cyc.size() - ab, S);
        check("bp_in_ready", m_if.in_ready, 1'b0);
        check("bp_y_stable", unstable, 0);
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b1;
        repeat (S + 3) step();
        check("bp_drained", out_hist.size() - ob, S);
        for (int i = 0; i < S; i++) begin
            if (ob + i < out_hist.size() && i < exp_q.size()) check($sformatf("bp_y_%0d", i), out_hist[ob+i], exp_q[i]);
        end

        // Reset with two beats in flight.
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_if.in_valid = 1'b1;
            m_if.op = 3'($urandom_range(0, 7)); m_if.a = 8'($urandom); m_if.b = 8'($urandom);
            step();
        end
        m_if.in_valid = 1'b0;
        check("mid_pre_out_valid", m_if.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_async_out_valid", m_if.out_valid, 1'b0);
        check("mid_async_done_cnt", done_cnt, 16'd0);
        step();
        step();
        rst_n = 1'b1;
        m_if.out_ready = 1'b1;
        ob = out_hist.size(); ov_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_if.out_valid) ov_seen++;
            step();
        end
        check("mid_no_emit", ov_seen, 0);
        check("mid_hist", out_hist.size() - ob, 0);
        check("mid_done_cnt", done_cnt, 16'd0);

        // Random traffic with random backpressure.
        took = 1'b1;
        for (int i = 0; i < 400; i++) begin
            m_if.out_ready = ($urandom_range(0, 9) < 6);
            if (took || !m_if.in_valid) begin
                m_if.in_valid = ($urandom_range(0, 9) < 7);
                m_if.op = 3'($urandom_range(0, 7)); m_if.a = 8'($urandom); m_if.b = 8'($urandom);
            end
            #1;
            took = m_if.in_valid && m_if.in_ready;
            step();
        end
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b1;
        repeat (2 * S + 4) step();
        check("rand_drained", mq.size(), 0);

        // Counter wrap on the 4-bit instance.
        do_reset();
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            m_if.in_valid = 1'b1;
            m_if.op = 3'($urandom_range(0, 7)); m_if.a = 8'($urandom); m_if.b = 8'($urandom);
            step();
        end
        m_if.in_valid = 1'b0;
        repeat (S + 3) step();
        check("wrap_done_cnt_w", done_cnt_w, 4'd1);
        check("wrap_done_cnt", done_cnt, 16'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
